// File: rtl/alu_md_control_unit.sv
// Registered ALU control decoder with an iterative multiply/divide unit and HI/LO registers.
// MD/MF/MT instructions stall while a multiply or divide is in flight; ALU ops never stall.
module alu_md_control_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_W      = $clog2(DATA_WIDTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  valid_in,
  input  logic [1:0]            alu_op,
  input  logic [5:0]            instruction_5_0,
  input  logic [DATA_WIDTH-1:0] rs_data,
  input  logic [DATA_WIDTH-1:0] rt_data,
  output logic                  stall,
  output logic [3:0]            alu_out,
  output logic                  out_valid,
  output logic                  illegal,
  output logic                  md_busy,
  output logic                  md_done,
  output logic [DATA_WIDTH-1:0] hi_out,
  output logic [DATA_WIDTH-1:0] lo_out,
  output logic [DATA_WIDTH-1:0] mf_data,
  output logic                  mf_valid
);

  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MTLO  = 6'b010011;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, FIX} md_state_t;

  md_state_t state, state_next;

  logic [3:0]            dec_code;
  logic                  dec_illegal, is_mul, is_div, is_signed, is_mf, is_mt;
  logic                  md_family, accept, md_start, div_zero;
  logic                  a_neg, b_neg;
  logic [DATA_WIDTH-1:0] a_mag, b_mag;

  logic [DATA_WIDTH-1:0] acc_hi, acc_lo, b_reg;
  logic [CNT_W-1:0]      cnt;
  logic                  op_div, neg_q, neg_r;

  logic [DATA_WIDTH:0]     mul_sum;
  logic [DATA_WIDTH:0]     div_shift;
  logic [DATA_WIDTH+1:0]   div_diff;
  logic                    div_ok;
  logic [2*DATA_WIDTH-1:0] prod, prod_s;
  logic [DATA_WIDTH-1:0]   fix_hi, fix_lo;

  always_comb begin
    dec_code    = 4'b0000;
    dec_illegal = 1'b0;
    is_mul      = 1'b0;
    is_div      = 1'b0;
    is_signed   = 1'b0;
    is_mf       = 1'b0;
    is_mt       = 1'b0;
    case (alu_op)
      2'b00: dec_code = 4'b0010;
      2'b01: dec_code = 4'b0110;
      2'b10: begin
        case (instruction_5_0)
          6'b100000:       dec_code = 4'b0010;
          6'b100010:       dec_code = 4'b0110;
          6'b100100:       dec_code = 4'b0000;
          6'b100101:       dec_code = 4'b0001;
          6'b100111:       dec_code = 4'b1100;
          6'b101010:       dec_code = 4'b0111;
          F_MFHI, F_MFLO:  is_mf = 1'b1;
          F_MTHI, F_MTLO:  is_mt = 1'b1;
          F_MULT:          begin is_mul = 1'b1; is_signed = 1'b1; end
          F_MULTU:         is_mul = 1'b1;
          F_DIV:           begin is_div = 1'b1; is_signed = 1'b1; end
          F_DIVU:          is_div = 1'b1;
          default:         begin dec_code = 4'b1111; dec_illegal = 1'b1; end
        endcase
      end
      default: begin dec_code = 4'b1111; dec_illegal = 1'b1; end
    endcase
  end

  // Handshake: an instruction is accepted on a rising edge where valid_in=1 and stall=0;
  // while stall=1 the issue stage must keep the instruction presented.
  assign md_busy   = (state != IDLE);
  assign md_family = is_mf | is_mt | is_mul | is_div;
  assign stall     = valid_in & md_busy & md_family;
  assign accept    = valid_in & ~stall;
  assign md_start  = accept & (is_mul | is_div);
  assign div_zero  = is_div & (rt_data == '0);

  assign a_neg = is_signed & rs_data[DATA_WIDTH-1];
  assign b_neg = is_signed & rt_data[DATA_WIDTH-1];
  assign a_mag = a_neg ? -rs_data : rs_data;
  assign b_mag = b_neg ? -rt_data : rt_data;

  // Shift-add step: {acc_hi,acc_lo} holds partial product above the unconsumed multiplier bits.
  assign mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, b_reg} : '0);
  // Restoring step: acc_hi is the partial remainder, acc_lo shifts dividend out and quotient in.
  assign div_shift = {acc_hi, acc_lo[DATA_WIDTH-1]};
  assign div_diff  = {1'b0, div_shift} - {2'b00, b_reg};
  assign div_ok    = ~div_diff[DATA_WIDTH+1];

  assign prod   = {acc_hi, acc_lo};
  assign prod_s = neg_q ? -prod : prod;
  assign fix_hi = op_div ? (neg_r ? -acc_hi : acc_hi) : prod_s[2*DATA_WIDTH-1:DATA_WIDTH];
  assign fix_lo = op_div ? (neg_q ? -acc_lo : acc_lo) : prod_s[DATA_WIDTH-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (md_start) state_next = div_zero ? FIX : RUN;
      RUN:     if (cnt == CNT_LAST) state_next = FIX;
      FIX:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_hi    <= '0;
      acc_lo    <= '0;
      b_reg     <= '0;
      cnt       <= '0;
      op_div    <= 1'b0;
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
      md_done   <= 1'b0;
      hi_out    <= '0;
      lo_out    <= '0;
      mf_data   <= '0;
      mf_valid  <= 1'b0;
      alu_out   <= 4'b0000;
      out_valid <= 1'b0;
      illegal   <= 1'b0;
    end else begin
      out_valid <= accept;
      illegal   <= accept & dec_illegal;
      if (accept) alu_out <= dec_code;

      if (state == IDLE && md_start) begin
        cnt    <= '0;
        op_div <= is_div;
        b_reg  <= b_mag;
        if (div_zero) begin
          // FIX then emits HI=dividend, LO=all ones without sign correction.
          acc_hi <= rs_data;
          acc_lo <= '1;
          neg_q  <= 1'b0;
          neg_r  <= 1'b0;
        end else begin
          acc_hi <= '0;
          acc_lo <= a_mag;
          neg_q  <= a_neg ^ b_neg;
          neg_r  <= a_neg;
        end
      end else if (state == RUN) begin
        cnt <= cnt + 1'b1;
        if (op_div) begin
          acc_hi <= div_ok ? div_diff[DATA_WIDTH-1:0] : div_shift[DATA_WIDTH-1:0];
          acc_lo <= {acc_lo[DATA_WIDTH-2:0], div_ok};
        end else begin
          {acc_hi, acc_lo} <= {mul_sum, acc_lo[DATA_WIDTH-1:1]};
        end
      end

      md_done <= (state == FIX);
      if (state == FIX) begin
        hi_out <= fix_hi;
        lo_out <= fix_lo;
      end else if (accept & is_mt) begin
        if (instruction_5_0[1]) lo_out <= rs_data;
        else                    hi_out <= rs_data;
      end

      mf_valid <= accept & is_mf;
      if (accept & is_mf) mf_data <= instruction_5_0[1] ? lo_out : hi_out;
    end
  end

endmodule

// File: doc/alu_md_control_unit.md
Name: alu_md_control_unit

Overview:
- Parametrised, clocked successor to the combinational ALU control decoder.
- Decodes alu_op plus funct into a registered 4-bit ALU control code.
- Adds an iterative multiply/divide unit (MULT/MULTU/DIV/DIVU) with HI/LO registers, MFHI/MFLO/MTHI/MTLO, and a stall handshake to the issue stage.
- Sits between instruction decode and the EX-stage ALU.

Parameters:
- DATA_WIDTH, 32, operand width and HI/LO width (even, >=4).
- CNT_W, $clog2(DATA_WIDTH)+1, iteration counter width (derived; do not override).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- valid_in  input  1  instruction present this cycle
- alu_op  input  2  main-control ALU op class
- instruction_5_0  input  6  funct field
- rs_data  input  DATA_WIDTH  operand A / dividend / MTHI-MTLO source
- rt_data  input  DATA_WIDTH  operand B / divisor
- stall  output  1  combinational; instruction not accepted, hold inputs
- alu_out  output  4  registered ALU control code
- out_valid  output  1  registered; alu_out belongs to an accepted instruction
- illegal  output  1  registered one-cycle pulse for undefined encoding
- md_busy  output  1  multiply/divide in progress
- md_done  output  1  one-cycle pulse; HI/LO just updated by MULT/DIV
- hi_out  output  DATA_WIDTH  HI register
- lo_out  output  DATA_WIDTH  LO register
- mf_data  output  DATA_WIDTH  registered MFHI/MFLO result
- mf_valid  output  1  one-cycle pulse with mf_data

Behaviour:
- Reset (async, rst_n=0): every output and register is 0, FSM returns to IDLE, and any in-flight op is aborted with no HI/LO update. Release is synchronous to clk.
- Accept: the cycle where valid_in=1 and stall=0. Every registered output reflects the instruction accepted at the prior edge; latency is 1.
- Decode table (alu_out):
  - alu_op=00 -> 0010
  - alu_op=01 -> 0110
  - alu_op=10 with funct:
    - 100000 -> 0010
    - 100010 -> 0110
    - 100100 -> 0000
    - 100101 -> 0001
    - 100111 -> 1100
    - 101010 -> 0111
  - MD/MF/MT funct (011000-011011, 010000-010011) -> 0000
  - Any other alu_op=10 funct, or alu_op=11 -> alu_out=1111, illegal=1.
- out_valid=1 for one cycle after each accept, else 0. When out_valid=0, alu_out holds its last value.
- stall=1 iff valid_in=1, md_busy=1, and funct is an MD/MF/MT op with alu_op=10. ALU ops never stall.
- MTHI/MTLO: at the accept edge, HI or LO <= rs_data.
- MFHI/MFLO: mf_data <= HI or LO at the accept edge; mf_valid pulses.
- MD FSM states are IDLE -> RUN -> FIX -> IDLE.
  - On accepting MULT/MULTU/DIV/DIVU: latch operands (signed ops use magnitudes and record result signs), counter=0, go to RUN.
  - RUN: one iteration per cycle, exactly DATA_WIDTH cycles. Multiply is shift-add; divide is restoring, one quotient bit per cycle. Then go to FIX.
  - FIX: apply signs and write HI/LO at the closing edge; md_done pulses in the following cycle; return to IDLE.
  - md_busy=1 in RUN and FIX: DATA_WIDTH+1 cycles starting the cycle after accept. HI/LO visible DATA_WIDTH+2 cycles after the accept edge.
- Multiply: {HI,LO} = full 2*DATA_WIDTH-bit product, signed for MULT, unsigned for MULTU.
- Divide: LO = quotient truncated toward zero; HI = remainder carrying the dividend's sign.
- Divide by zero skips RUN and goes IDLE->FIX; result is HI=dividend, LO=all ones; busy lasts 1 cycle.
- Signed overflow (most-negative / -1): LO=most-negative, HI=0.
- MT* is stalled while busy, so the FSM is the only HI/LO writer during an op.

Test Plan:
- Decode sweep, all alu_op/funct listed, valid_in=1 each cycle -> alu_out matches table one cycle later. Funct 000001 with alu_op=10 -> alu_out=1111 and illegal pulse.
- MULT rs=FFFFFFFF, rt=00000002 -> after 34 edges HI=FFFFFFFF, LO=FFFFFFFE, md_done pulse. MULTU same operands -> HI=00000001, LO=FFFFFFFE.
- DIV rs=FFFFFFF9 (-7), rt=00000002 -> LO=FFFFFFFD, HI=FFFFFFFF. DIVU 100/7 -> LO=0000000E, HI=00000002. DIV rs=80000000, rt=FFFFFFFF -> LO=80000000, HI=0.
- Divide by zero, rs=12345678 -> busy for 1 cycle, HI=12345678, LO=FFFFFFFF.
- MFLO issued 3 cycles after a MULT accept -> stall=1 until busy falls. Meanwhile ADD issues unstalled (alu_out=0010). MFLO then returns the new LO with a mf_valid pulse.
- rst_n pulsed low mid-RUN -> all outputs 0 immediately (async). After release: no md_done, HI=LO=0.
